// File: rtl/pe_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_REQ PE controllers.
// Optional ISSUE watchdog enabled by defining ARB_TIMEOUT_EN.
module pe_mem_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_read,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic [DATA_W-1:0]           req_rdata,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_ack,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int IDW = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]         state;
    logic [IDW-1:0]     last_grant;
    logic [IDW-1:0]     sel;
    logic               found;
    logic [NUM_REQ-1:0] pending;
    logic               tmo_hit;

    assign pending = req_read | req_write;

    // Scan starts just after the previous owner, so every pending PE is served before a repeat.
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_grant) + off) % NUM_REQ;
            if (!found && pending[IDW'(idx)]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
    end

    assign busy = (state != S_IDLE);

    always_comb begin
        req_ack = '0;
        if (state == S_RESP) begin
            req_ack[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            last_grant  <= IDW'(NUM_REQ - 1);
            grant_id    <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            req_rdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant_id    <= sel;
                        last_grant  <= sel;
                        mem_address <= req_address[int'(sel)*ADDR_W +: ADDR_W];
                        mem_wdata   <= req_wdata[int'(sel)*DATA_W +: DATA_W];
                        // A PE asserting both strobes is treated as a write.
                        mem_write   <= req_write[sel];
                        mem_read    <= ~req_write[sel];
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_ack) begin
                        req_rdata <= mem_rdata;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= S_RESP;
                    end else if (tmo_hit) begin
                        req_rdata <= '0;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? 16 : 8;

    logic [CNT_W-1:0] tmo_cnt;

    // Counts ISSUE cycles; the last allowed cycle without mem_ack aborts the access.
    assign tmo_hit = (state == S_ISSUE) && !mem_ack &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_hit;
            if (state != S_ISSUE) begin
                tmo_cnt <= '0;
            end else if (!mem_ack) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
`else
    // Watchdog absent: ISSUE waits for mem_ack forever; the compare is always false.
    assign tmo_hit     = (TIMEOUT_CYC < 0);
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_pe_mem_arbiter.sv
// Scoreboard bench for pe_mem_arbiter: directed requests, a memory model, and
// decoupled monitors for the memory port and the PE acknowledge path.
module tb_pe_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef ARB_TIMEOUT_EN
    localparam int TMO = 5;
`else
    localparam int TMO = 255;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [N-1:0]      req_read = '0;
    logic [N-1:0]      req_write = '0;
    logic [N*AW-1:0]   req_address = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic [N-1:0]      req_ack;
    logic [DW-1:0]     req_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [AW-1:0]     mem_address;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic [1:0]        grant_id;
    logic              busy;
    logic              timeout_err;

    pe_mem_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_read(req_read), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_rdata(req_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  ack;
        logic [DW-1:0] rdata;
        bit            chk_rdata;
        bit            tmo;
        int            due;
    } resp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            wr;
    } memx_t;

    resp_t exp_q[$];
    memx_t mem_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int extra[N] = '{default: 0};

    bit mem_en = 1'b1;
    int ack_delay = 1;
    bit stray_ack = 1'b0;
    int wait_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rdata_fn(input logic [AW-1:0] a);
        if (a == 32'h40) return 32'hDEAD_BEEF;
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory model: acks after ack_delay strobe cycles with address-derived data.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (!rst_n) begin
            wait_cnt = 0;
        end else if (stray_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hFFFF_FFFF;
        end else if ((mem_read || mem_write) && mem_en) begin
            if (wait_cnt >= ack_delay - 1) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata_fn(mem_address);
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Memory-port monitor: each new strobe pops one expected access; address must hold while strobed.
    memx_t cur;
    bit    cur_ok = 1'b0;
    bit    prev_strobe = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_strobe = 1'b0;
            cur_ok      = 1'b0;
        end else begin
            if (mem_read || mem_write) begin
                if (!prev_strobe) begin
                    if (mem_q.size() == 0) begin
                        check_output("unexpected strobe", {62'd0, mem_read, mem_write}, 64'd0);
                        cur_ok = 1'b0;
                    end else begin
                        cur    = mem_q.pop_front();
                        cur_ok = 1'b1;
                        check_output("strobe type", {62'd0, mem_read, mem_write},
                                     cur.wr ? 64'd1 : 64'd2);
                        if (cur.wr) check_output("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
                    end
                end
                if (cur_ok) check_output("mem_address", 64'(mem_address), 64'(cur.addr));
            end
            prev_strobe = mem_read || mem_write;
        end
    end

    // Ack monitor: every req_ack pulse is matched against the oldest expected response.
    always @(negedge clk) begin
        resp_t e;
        if (rst_n && req_ack != '0) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected req_ack", 64'(req_ack), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_output("req_ack", 64'(req_ack), 64'(e.ack));
                if (e.chk_rdata) check_output("req_rdata", 64'(req_rdata), 64'(e.rdata));
                check_output("timeout_err", 64'(timeout_err), 64'(e.tmo));
                if (e.due != 0) check_output("ack cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // One cycle of requester behaviour: a PE drops its request after its ack unless told to hold.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (rst_n && req_ack[i]) begin
                if (extra[i] > 0) begin
                    extra[i]--;
                end else begin
                    req_read[i]  = 1'b0;
                    req_write[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic apply_stimulus(input int pe, input bit rd, input bit wr,
                                  input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        req_address[pe*AW +: AW] = addr;
        req_wdata[pe*DW +: DW]   = wdata;
        req_read[pe]             = rd;
        req_write[pe]            = wr;
    endtask

    task automatic push_resp(input logic [N-1:0] ack, input logic [DW-1:0] rdata,
                             input bit chk, input bit tmo, input int due);
        resp_t r;
        r.ack = ack; r.rdata = rdata; r.chk_rdata = chk; r.tmo = tmo; r.due = due;
        exp_q.push_back(r);
    endtask

    task automatic push_mem(input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input bit wr);
        memx_t m;
        m.addr = addr; m.wdata = wdata; m.wr = wr;
        mem_q.push_back(m);
    endtask

    task automatic wait_drain(input string name, input int limit);
        for (int n = 0; n < limit && exp_q.size() != 0; n++) tick();
        if (exp_q.size() != 0) begin
            check_output(name, 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        tick();
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " strobes"}, {62'd0, mem_read, mem_write}, 64'd0);
        check_output({tag, " mem_address"}, 64'(mem_address), 64'd0);
        check_output({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
        check_output({tag, " status"}, {55'd0, busy, grant_id, timeout_err, req_ack}, 64'd0);
        check_output({tag, " req_rdata"}, 64'(req_rdata), 64'd0);
    endtask

    initial begin
        int t0;
        #2 rst_n = 1'b0;
        tick(); tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // mem_ack while idle must not start anything
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        tick(); tick();
        check_output("stray ack busy", 64'(busy), 64'd0);
        check_output("stray ack req_ack", 64'(req_ack), 64'd0);

        // Fairness: all four request together, PE0 keeps holding after its first ack
        ack_delay = 1;
        extra[0]  = 1;
        t0 = cyc;
        for (int i = 0; i < N; i++) push_mem(32'h100 + 32'(i) * 32'h10, 32'h0, 1'b0);
        push_mem(32'h100, 32'h0, 1'b0);
        push_resp(4'b0001, 32'hC0DE_0100, 1'b1, 1'b0, t0 + 2);
        push_resp(4'b0010, 32'hC0DE_0110, 1'b1, 1'b0, t0 + 5);
        push_resp(4'b0100, 32'hC0DE_0120, 1'b1, 1'b0, t0 + 8);
        push_resp(4'b1000, 32'hC0DE_0130, 1'b1, 1'b0, t0 + 11);
        push_resp(4'b0001, 32'hC0DE_0100, 1'b1, 1'b0, t0 + 14);
        for (int i = 0; i < N; i++) apply_stimulus(i, 1'b1, 1'b0, 32'h100 + 32'(i) * 32'h10, 32'h0);
        wait_drain("fairness drain", 60);

        // Single read with ack in the third ISSUE cycle
        ack_delay = 3;
        t0 = cyc;
        push_mem(32'h40, 32'h0, 1'b0);
        push_resp(4'b0010, 32'hDEAD_BEEF, 1'b1, 1'b0, t0 + 4);
        apply_stimulus(1, 1'b1, 1'b0, 32'h40, 32'h0);
        wait_drain("single read drain", 40);

        // Read+write together resolves to a write
        ack_delay = 1;
        t0 = cyc;
        push_mem(32'h8, 32'h55, 1'b1);
        push_resp(4'b0100, 32'h0, 1'b0, 1'b0, t0 + 2);
        apply_stimulus(2, 1'b1, 1'b1, 32'h8, 32'h55);
        wait_drain("rw conflict drain", 40);

        // Withdrawal right after grant: latched address still used, still acked, never regranted
        ack_delay = 2;
        t0 = cyc;
        push_mem(32'h300, 32'h0, 1'b0);
        push_resp(4'b1000, 32'hC0DE_0300, 1'b1, 1'b0, t0 + 3);
        apply_stimulus(3, 1'b1, 1'b0, 32'h300, 32'h0);
        tick();
        req_read[3] = 1'b0;
        req_address[3*AW +: AW] = 32'hBAD;
        wait_drain("withdraw drain", 40);
        tick(); tick(); tick();
        check_output("withdraw no regrant", 64'(busy), 64'd0);

        // Reset in the middle of ISSUE, then PE0 beats PE2
        mem_en = 1'b0;
        push_mem(32'h208, 32'h0, 1'b0);
        apply_stimulus(2, 1'b1, 1'b0, 32'h208, 32'h0);
        for (int n = 0; n < 10 && !mem_read; n++) tick();
        tick();
        check_output("strobe before reset", 64'(mem_read), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid reset");
        mem_en    = 1'b1;
        ack_delay = 1;
        apply_stimulus(0, 1'b1, 1'b0, 32'h4, 32'h0);
        push_mem(32'h4, 32'h0, 1'b0);
        push_mem(32'h208, 32'h0, 1'b0);
        push_resp(4'b0001, 32'hC0DE_0004, 1'b1, 1'b0, 0);
        push_resp(4'b0100, 32'hC0DE_0208, 1'b1, 1'b0, 0);
        tick(); tick();
        rst_n = 1'b1;
        wait_drain("post reset drain", 40);

        // Memory that never answers
        mem_en = 1'b0;
        t0 = cyc;
        push_mem(32'h44, 32'h0, 1'b0);
`ifdef ARB_TIMEOUT_EN
        push_resp(4'b0010, 32'h0, 1'b1, 1'b1, t0 + 6);
        apply_stimulus(1, 1'b1, 1'b0, 32'h44, 32'h0);
        wait_drain("timeout drain", 40);
        mem_en = 1'b1;
`else
        push_resp(4'b0010, 32'hC0DE_0044, 1'b1, 1'b0, 0);
        apply_stimulus(1, 1'b1, 1'b0, 32'h44, 32'h0);
        for (int n = 0; n < 40; n++) tick();
        check_output("stalled strobe", 64'(mem_read), 64'd1);
        check_output("stalled busy", 64'(busy), 64'd1);
        check_output("stalled timeout_err", 64'(timeout_err), 64'd0);
        mem_en    = 1'b1;
        ack_delay = 1;
        wait_drain("stall drain", 40);
`endif

        tick(); tick();
        check_output("leftover mem accesses", 64'(mem_q.size()), 64'd0);
        check_output("final idle", 64'(busy), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/pe_mem_arbiter.md
Name: pe_mem_arbiter

Overview:
- Round-robin arbiter that shares one data-memory port between NUM_REQ processing-element controllers in the CGRA array.
- Each PE controller issues a level-held read or write with its address, and receives a one-cycle ack plus shared read data.
- Sits between the PE controllers' load/store handshake and the single memory port, which uses the mem_read / mem_write / mem_address / mem_ack handshake.
- Serialises accesses with fair rotating priority, one transaction in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesting PEs (2..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 255, cycles to wait for mem_ack before abort (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_read  in  NUM_REQ  per-PE read request, held until that PE's req_ack
- req_write  in  NUM_REQ  per-PE write request, held until that PE's req_ack
- req_address  in  NUM_REQ*ADDR_W  flattened addresses; PE i at bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  flattened write data; same packing as req_address
- req_ack  out  NUM_REQ  one-hot, one-cycle completion pulse
- req_rdata  out  DATA_W  read data; valid in the req_ack cycle, held until the next capture
- mem_read  out  1  memory read strobe, level, held until mem_ack
- mem_write  out  1  memory write strobe, level, held until mem_ack
- mem_address  out  ADDR_W  latched address of the granted transaction
- mem_wdata  out  DATA_W  latched write data of the granted transaction
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one-cycle pulse
- grant_id  out  $clog2(NUM_REQ)  owner index, valid while busy
- busy  out  1  high in ISSUE and RESP
- timeout_err  out  1  abort flag; constant 0 without ARB_TIMEOUT_EN

Behaviour:

Reset:
- All outputs are 0. State is IDLE. The rotate pointer last_grant = NUM_REQ-1, so PE 0 has first priority.
- Reset mid-transaction aborts immediately. No ack is issued.

FSM states are IDLE, ISSUE, RESP.

IDLE:
- pending[i] = req_read[i] | req_write[i].
- If any bit is pending, select the first pending index scanning last_grant+1, last_grant+2, … modulo NUM_REQ.
- Latch that PE's address, wdata, id and type. If both read and write are set, the transaction is a write.
- Set last_grant = id and go to ISSUE.
- mem_ack seen in IDLE is ignored.

ISSUE:
- mem_read or mem_write is asserted from the cycle after the grant, together with the latched address and data.
- On mem_ack: capture mem_rdata into req_rdata (writes capture too; the value is don't-care), drop the strobes in the next cycle, and go to RESP.

RESP:
- req_ack[grant_id] = 1 for exactly one cycle, then go to IDLE.

Latency and requester rules:
- Request first seen in IDLE at cycle 0 → strobe in cycle 1 → mem_ack in cycle k (k ≥ 1) → req_ack in cycle k+1.
- Minimum back-to-back spacing is 3 cycles per transaction.
- A requester must deassert in the cycle after its req_ack; IDLE re-samples only then.
- A request withdrawn before grant is simply never served.
- A request withdrawn after grant still completes from the latched values and is still acked.
- Simultaneous requests are resolved by rotation only; no PE is served twice while another PE is pending.
- The address and data of a granted transaction never change while a strobe is high.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - An 8..16-bit counter clears on entering ISSUE and increments each ISSUE cycle without mem_ack.
  - When the count reaches TIMEOUT_CYC, drop the strobes and go to RESP with req_rdata = 0.
  - timeout_err is 1 in that RESP cycle only.
  - mem_ack arriving in the same cycle as the timeout wins (normal completion).
- When not defined:
  - ISSUE waits indefinitely.
  - No counter is built.
  - timeout_err is tied 0.

Test Plan:
1. Single read: PE1 req_read, address 0x40; mem_ack in the 3rd ISSUE cycle with mem_rdata 0xDEADBEEF → mem_address = 0x40 while mem_read is high; req_ack = 0b0010 for one cycle with req_rdata = 0xDEADBEEF.
2. Fairness: all 4 PEs hold read requests after reset, memory acks after 1 cycle → grant order 0,1,2,3,0, each ack 3 cycles apart.
3. Read+write conflict: PE2 sets both, address 0x8, wdata 0x55 → mem_write = 1, mem_read = 0, mem_wdata = 0x55.
4. Withdrawal: PE3 drops its request the cycle after grant → the transaction still issues to address PE3 latched; req_ack[3] pulses; no re-grant to PE3.
5. Reset mid-ISSUE: rst_n low while mem_read = 1 → all outputs 0 at once; after release PE0 wins over PE2.
6. ARB_TIMEOUT_EN, TIMEOUT_CYC = 5, no mem_ack → strobe drops after 5 ISSUE cycles; req_ack and timeout_err pulse together with req_rdata = 0. Without the macro, the strobe stays high indefinitely.
